// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding,
// reset-cause encoding and a counter-width helper.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POWER = 2'b00,
        CAUSE_SOFT  = 2'b01,
        CAUSE_WDT   = 2'b10
    } rst_cause_t;

    // Bits needed to hold every value from 0 up to and including max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Two-flop reset synchronizer: assertion is asynchronous, deassertion is
// retimed to clk through two flops so downstream logic leaves reset cleanly.
module rst_sync (
    input  logic clk,
    input  logic rst,
    output logic rst_s
);

    logic meta;

    // Async set on rst, shift zeros through the two-stage chain on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= 1'b1;
            rst_s <= 1'b1;
        end else begin
            meta  <= 1'b0;
            rst_s <= meta;
        end
    end

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: holds all domain resets, releases them one by one in
// index order with a fixed gap, then supervises a software watchdog.
// soft_rst_req or a watchdog timeout re-runs the whole sequence.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8,
    parameter int WDT_TIMEOUT = 1000,
    parameter int WDT_EN      = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   soft_rst_req,
    input  logic                   wdt_kick,
    output logic [NUM_DOMAINS-1:0] dom_rst_o,
    output logic                   all_ready,
    output logic                   busy,
    output logic                   wdt_expired,
    output logic [1:0]             rst_cause,
    output logic [1:0]             dbg_state
);

    // One counter serves both the hold phase and the inter-stage gap.
    localparam int SEQ_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int SEQ_W   = cnt_width(SEQ_MAX);
    localparam int IDX_W   = cnt_width(NUM_DOMAINS);
    localparam int WDT_W   = cnt_width(WDT_TIMEOUT);

    logic             rst_s;
    state_t           state;
    state_t           state_n;
    logic [SEQ_W-1:0] seq_cnt;
    logic [IDX_W-1:0] stage_idx;
    logic [WDT_W-1:0] wdt_cnt;
    rst_cause_t       cause_q;
    logic             wdt_fire;
    logic             restart;
    logic             gap_done;
    logic             last_gap;

    rst_sync u_rst_sync (
        .clk   (clk),
        .rst   (rst),
        .rst_s (rst_s)
    );

    // The hold phase runs one extra count so the first release lands HOLD_CYCLES
    // edges after the first edge out of reset (or after the restart edge).
    assign gap_done  = (seq_cnt == SEQ_W'(STAGE_GAP - 1));
    assign last_gap  = (stage_idx == IDX_W'(NUM_DOMAINS - 2));
    assign rst_cause = cause_q;
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) state <= ASSERT;
        else       state <= state_n;
    end

    // Next-state logic, watchdog expiry and restart detection.
    always_comb begin
        state_n  = state;
        // Expiry fires on the edge where the count would reach WDT_TIMEOUT-1;
        // a kick in that same cycle suppresses it.
        wdt_fire = (state == RUN) && (WDT_EN != 0) && !wdt_kick &&
                   (wdt_cnt == WDT_W'(WDT_TIMEOUT - 2));
        restart  = soft_rst_req || wdt_fire;
        case (state)
            ASSERT:  if (seq_cnt == SEQ_W'(HOLD_CYCLES))
                         state_n = (NUM_DOMAINS == 1) ? RUN : RELEASE;
            RELEASE: if (gap_done && last_gap) state_n = RUN;
            RUN:     state_n = RUN;
            default: state_n = ASSERT;
        endcase
        if (restart) state_n = ASSERT;
    end

    // Hold/gap counter and stage index; both clear on every state change.
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            seq_cnt   <= '0;
            stage_idx <= '0;
        end else if (restart || state_n != state) begin
            seq_cnt   <= '0;
            stage_idx <= '0;
        end else if (state == RELEASE && gap_done) begin
            seq_cnt   <= '0;
            stage_idx <= stage_idx + 1'b1;
        end else if (state != RUN) begin
            seq_cnt   <= seq_cnt + 1'b1;
        end
    end

    // Watchdog counter: runs only while staying in RUN, cleared by a kick.
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s)
            wdt_cnt <= '0;
        else if (state == RUN && state_n == RUN && WDT_EN != 0)
            wdt_cnt <= wdt_kick ? '0 : wdt_cnt + 1'b1;
        else
            wdt_cnt <= '0;
    end

    // Expiry pulse and cause of the most recent sequence; soft wins a tie.
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            wdt_expired <= 1'b0;
            cause_q     <= CAUSE_POWER;
        end else begin
            wdt_expired <= wdt_fire;
            if (soft_rst_req)  cause_q <= CAUSE_SOFT;
            else if (wdt_fire) cause_q <= CAUSE_WDT;
        end
    end

    // Outputs decoded from state: domains above stage_idx are still held.
    always_comb begin
        dom_rst_o = '1;
        all_ready = 1'b0;
        busy      = 1'b1;
        case (state)
            RELEASE: begin
                for (int i = 0; i < NUM_DOMAINS; i++)
                    dom_rst_o[i] = (i > int'(stage_idx));
            end
            RUN: begin
                dom_rst_o = '0;
                all_ready = 1'b1;
                busy      = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: power-on timing, soft restarts, watchdog
// expiry / kick / tie cases, async reset mid-release, and a WDT_EN=0 instance.
module tb_rst_sequencer;
    import rst_seq_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rst2 = 1'b1;
    logic         soft_rst_req = 1'b0;
    logic         wdt_kick = 1'b0;
    logic         soft_rst_req2 = 1'b0;
    logic         wdt_kick2 = 1'b0;

    logic [N-1:0] dom_rst_o, dom_rst_o2;
    logic         all_ready, all_ready2;
    logic         busy, busy2;
    logic         wdt_expired, wdt_expired2;
    logic [1:0]   rst_cause, rst_cause2;
    logic [1:0]   dbg_state, dbg_state2;

    int checks = 0;
    int failures = 0;
    int cur_edge = -3;
    int pulse_cnt = 0;
    int pulse_cnt2 = 0;

    rst_sequencer u_dut (
        .clk          (clk),
        .rst          (rst),
        .soft_rst_req (soft_rst_req),
        .wdt_kick     (wdt_kick),
        .dom_rst_o    (dom_rst_o),
        .all_ready    (all_ready),
        .busy         (busy),
        .wdt_expired  (wdt_expired),
        .rst_cause    (rst_cause),
        .dbg_state    (dbg_state)
    );

    rst_sequencer #(.WDT_EN(0)) u_dut_nowdt (
        .clk          (clk),
        .rst          (rst2),
        .soft_rst_req (soft_rst_req2),
        .wdt_kick     (wdt_kick2),
        .dom_rst_o    (dom_rst_o2),
        .all_ready    (all_ready2),
        .busy         (busy2),
        .wdt_expired  (wdt_expired2),
        .rst_cause    (rst_cause2),
        .dbg_state    (dbg_state2)
    );

    // Clock.
    always #5 clk = ~clk;

    // Count watchdog pulses on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (wdt_expired === 1'b1)  pulse_cnt++;
        if (wdt_expired2 === 1'b1) pulse_cnt2++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
        cur_edge++;
    endtask

    task automatic to_edge(input int n);
        while (cur_edge < n) tick();
    endtask

    task automatic pulse_soft_at(input int n);
        to_edge(n - 1);
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
    endtask

    task automatic pulse_kick_at(input int n);
        to_edge(n - 1);
        wdt_kick = 1'b1;
        tick();
        wdt_kick = 1'b0;
    endtask

    initial begin
        // Held in reset.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dom",   dom_rst_o,   4'hF);
        chk("reset_ready", all_ready,   1'b0);
        chk("reset_busy",  busy,        1'b1);
        chk("reset_wdt",   wdt_expired, 1'b0);
        chk("reset_cause", rst_cause,   CAUSE_POWER);
        chk("reset_state", dbg_state,   ASSERT);

        // Release: two synchronizer edges, then E0.
        rst  = 1'b0;
        rst2 = 1'b0;
        cur_edge = -3;
        to_edge(-1);
        chk("sync_dom", dom_rst_o, 4'hF);

        // Power-on sequence.
        to_edge(15);  chk("po_e15_dom", dom_rst_o, 4'hF);
        to_edge(16);  chk("po_e16_dom", dom_rst_o, 4'hE);
                      chk("po_e16_state", dbg_state, RELEASE);
        to_edge(23);  chk("po_e23_dom", dom_rst_o, 4'hE);
        to_edge(24);  chk("po_e24_dom", dom_rst_o, 4'hC);
        to_edge(32);  chk("po_e32_dom", dom_rst_o, 4'h8);
        to_edge(39);  chk("po_e39_ready", all_ready, 1'b0);
                      chk("po_e39_busy", busy, 1'b1);
        to_edge(40);  chk("po_e40_dom", dom_rst_o, 4'h0);
                      chk("po_e40_ready", all_ready, 1'b1);
                      chk("po_e40_busy", busy, 1'b0);
                      chk("po_e40_cause", rst_cause, CAUSE_POWER);
                      chk("po_e40_state", dbg_state, RUN);

        // Soft restart from RUN at E100.
        pulse_soft_at(100);
        chk("soft_e100_dom",   dom_rst_o, 4'hF);
        chk("soft_e100_busy",  busy, 1'b1);
        chk("soft_e100_ready", all_ready, 1'b0);
        chk("soft_e100_cause", rst_cause, CAUSE_SOFT);
        to_edge(116); chk("soft_e116_dom", dom_rst_o, 4'hF);
        to_edge(117); chk("soft_e117_dom", dom_rst_o, 4'hE);
        to_edge(141); chk("soft_e141_ready", all_ready, 1'b1);

        // No kicks after RUN entry at E141: expiry edge is E141+999.
        to_edge(1139); chk("wdt_e1139_pulse", wdt_expired, 1'b0);
                       chk("wdt_e1139_ready", all_ready, 1'b1);
        to_edge(1140); chk("wdt_e1140_pulse", wdt_expired, 1'b1);
                       chk("wdt_e1140_dom", dom_rst_o, 4'hF);
                       chk("wdt_e1140_cause", rst_cause, CAUSE_WDT);
                       chk("wdt_e1140_busy", busy, 1'b1);
        to_edge(1141); chk("wdt_e1141_pulse", wdt_expired, 1'b0);
                       chk("wdt_pulse_count1", pulse_cnt, 1);
        to_edge(1157); chk("wdt_e1157_dom", dom_rst_o, 4'hE);
        to_edge(1181); chk("wdt_e1181_ready", all_ready, 1'b1);

        // Regular kicks every 500 cycles keep RUN alive.
        pulse_kick_at(1681);
        pulse_kick_at(2181);
        pulse_kick_at(2681);
        to_edge(3000); chk("kick_e3000_ready", all_ready, 1'b1);
        // Kick in the expiry cycle (E2681+999) suppresses the pulse.
        pulse_kick_at(3680);
        to_edge(3681); chk("kick_exp_pulse", wdt_expired, 1'b0);
                       chk("kick_exp_ready", all_ready, 1'b1);
                       chk("kick_pulse_count", pulse_cnt, 1);

        // Soft request together with expiry at E3680+999.
        pulse_soft_at(4679);
        chk("tie_pulse", wdt_expired, 1'b1);
        chk("tie_cause", rst_cause, CAUSE_SOFT);
        chk("tie_dom",   dom_rst_o, 4'hF);
        to_edge(4681); chk("tie_pulse_count", pulse_cnt, 2);

        // Soft request during RELEASE restarts from ASSERT.
        to_edge(4696); chk("rel_e4696_dom", dom_rst_o, 4'hE);
        to_edge(4704); chk("rel_e4704_dom", dom_rst_o, 4'hC);
        pulse_soft_at(4705);
        chk("rel_soft_dom",   dom_rst_o, 4'hF);
        chk("rel_soft_state", dbg_state, ASSERT);
        to_edge(4721); chk("rel_e4721_dom", dom_rst_o, 4'hF);
        to_edge(4722); chk("rel_e4722_dom", dom_rst_o, 4'hE);
        to_edge(4738); chk("rel_e4738_dom", dom_rst_o, 4'h8);

        // Async reset mid-RELEASE at stage 2, checked before any clock edge.
        to_edge(4739);
        #3;
        rst = 1'b1;
        #1;
        chk("async_dom",   dom_rst_o, 4'hF);
        chk("async_ready", all_ready, 1'b0);
        chk("async_busy",  busy, 1'b1);
        chk("async_cause", rst_cause, CAUSE_POWER);
        chk("async_state", dbg_state, ASSERT);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cur_edge = -3;
        to_edge(-1);   chk("re_sync_dom", dom_rst_o, 4'hF);
        to_edge(15);   chk("re_e15_dom", dom_rst_o, 4'hF);
        to_edge(16);   chk("re_e16_dom", dom_rst_o, 4'hE);
        to_edge(40);   chk("re_e40_ready", all_ready, 1'b1);
                       chk("re_e40_cause", rst_cause, CAUSE_POWER);

        // Watchdog-disabled instance: no kicks for over 5000 cycles.
        to_edge(400);
        chk("nowdt_ready", all_ready2, 1'b1);
        chk("nowdt_busy",  busy2, 1'b0);
        chk("nowdt_dom",   dom_rst_o2, 4'h0);
        chk("nowdt_state", dbg_state2, RUN);
        chk("nowdt_pulses", pulse_cnt2, 0);
        chk("nowdt_cause", rst_cause2, CAUSE_POWER);
        chk("main_e400_ready", all_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
